// File: rtl/sort_pkg.sv
// sort_pkg: shared state encoding, default sizes and word type for the frame sorter.
package sort_pkg;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_ADDRESS = 4;
    typedef logic [DEF_WIDTH-1:0] word_t;
    typedef enum logic [1:0] {IDLE, LOAD, SORT, UNLOAD} state_t;
endpackage

// File: rtl/sort_cmp_swap.sv
// sort_cmp_swap: orders two words; signed when SORT_SIGNED_EN is defined, unsigned otherwise.
module sort_cmp_swap #(
    parameter int WIDTH = sort_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             swap
);
`ifdef SORT_SIGNED_EN
    assign swap = $signed(a) > $signed(b);
`else
    assign swap = a > b;
`endif
    assign lo = swap ? b : a;
    assign hi = swap ? a : b;
endmodule

// File: rtl/axis_sort_ctrl.sv
// axis_sort_ctrl: loads one AXI-Stream frame, bubble-sorts it in place, streams it out.
// Comparison signedness is selected by SORT_SIGNED_EN inside sort_cmp_swap.
module axis_sort_ctrl
    import sort_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ADDRESS = DEF_ADDRESS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   tdata,
    input  logic               tvalid,
    input  logic               tlast,
    output logic               tready,
    output logic [WIDTH-1:0]   odata,
    output logic               ovalid,
    output logic               olast,
    input  logic               oready,
    output logic               busy,
    output logic [ADDRESS:0]   frame_len,
    output logic               err_trunc
);
    localparam int DEPTH = 2**ADDRESS;
    localparam logic [ADDRESS:0] ONE = 1;

    state_t             state_q;
    logic [ADDRESS:0]   count_q, frame_len_q, n_new;
    logic [ADDRESS-1:0] rd_q, i_q, bound_q, ip1;
    logic               trunc_q, swapped_q, err_q, swap, ld_we, sw_we;
    logic [WIDTH-1:0]   lo, hi;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    sort_cmp_swap #(.WIDTH(WIDTH)) u_cmp (
        .a(mem_q[i_q]), .b(mem_q[ip1]), .lo(lo), .hi(hi), .swap(swap)
    );

    // count_q[ADDRESS] set means the buffer is full; further beats only saturate
    assign n_new     = count_q[ADDRESS] ? count_q : count_q + 1'b1;
    assign ip1       = i_q + 1'b1;
    assign ld_we     = state_q == LOAD && tvalid && !count_q[ADDRESS];
    assign sw_we     = state_q == SORT && swap;
    assign tready    = state_q == LOAD;
    assign busy      = state_q == SORT || state_q == UNLOAD;
    assign ovalid    = state_q == UNLOAD;
    assign odata     = ovalid ? mem_q[rd_q] : '0;
    assign olast     = ovalid && ({1'b0, rd_q} + ONE == frame_len_q);
    assign frame_len = frame_len_q;
    assign err_trunc = err_q;

    always_ff @(posedge clk) begin
        if (ld_we) mem_q[count_q[ADDRESS-1:0]] <= tdata;
        if (sw_we) begin
            mem_q[i_q] <= lo;
            mem_q[ip1] <= hi;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            frame_len_q <= '0;
            rd_q        <= '0;
            i_q         <= '0;
            bound_q     <= '0;
            trunc_q     <= 1'b0;
            swapped_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    count_q <= '0;
                    trunc_q <= 1'b0;
                    state_q <= LOAD;
                end
                LOAD: if (tvalid) begin
                    count_q <= n_new;
                    if (count_q[ADDRESS]) trunc_q <= 1'b1;
                    if (tlast) begin
                        frame_len_q <= n_new;
                        err_q       <= trunc_q | count_q[ADDRESS];
                        i_q         <= '0;
                        swapped_q   <= 1'b0;
                        bound_q     <= n_new[ADDRESS-1:0] - 2'd2;
                        state_q     <= n_new > ONE ? SORT : UNLOAD;
                    end
                end
                SORT: if (i_q == bound_q) begin
                    if (!(swapped_q | swap) || bound_q == '0) state_q <= UNLOAD;
                    i_q       <= '0;
                    swapped_q <= 1'b0;
                    bound_q   <= bound_q - 1'b1;
                end else begin
                    i_q       <= ip1;
                    swapped_q <= swapped_q | swap;
                end
                UNLOAD: if (oready) begin
                    rd_q <= olast ? '0 : rd_q + 1'b1;
                    if (olast) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_sort_ctrl.sv
// tb_axis_sort_ctrl: table-driven frame vectors plus a mid-sort reset sequence.
module tb_axis_sort_ctrl;
    logic        clk = 0, reset = 1, tvalid = 0, tlast = 0, oready = 0;
    logic [15:0] tdata = 0;
    logic        tready, ovalid, olast, busy, err_trunc;
    logic [15:0] odata;
    logic [4:0]  frame_len;

    axis_sort_ctrl #(.WIDTH(16), .ADDRESS(4)) dut (
        .clk(clk), .reset(reset), .tdata(tdata), .tvalid(tvalid), .tlast(tlast),
        .tready(tready), .odata(odata), .ovalid(ovalid), .olast(olast), .oready(oready),
        .busy(busy), .frame_len(frame_len), .err_trunc(err_trunc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int               n;
        logic [19:0][15:0] din;
        int               m;
        logic [15:0][15:0] dout;
        logic [4:0]       flen;
        logic             err;
        int               sc;
        logic             rnd;
    } vec_t;

    vec_t tv [5];
    vec_t cur;
    int   vectors = 0, fails = 0;
    int   err_cnt = 0, sort_cnt = 0;

    always @(negedge clk) begin
        err_cnt  <= err_cnt + int'(err_trunc);
        sort_cnt <= sort_cnt + int'(busy && !ovalid);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic send_frame();
        for (int k = 0; k < cur.n; k++) begin
            tdata  = cur.din[k];
            tvalid = 1'b1;
            tlast  = k == cur.n - 1;
            for (int w = 0; w < 100 && !tready; w++) @(negedge clk);
            if (!tready) chk("tready_timeout", 0, 1);
            @(negedge clk);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic recv_frame();
        int got = 0, guard = 0;
        bit held = 0;
        logic [15:0] hd;
        logic hl;
        while (got < cur.m && guard < 3000) begin
            if (held) begin
                chk("stall_data", odata, hd);
                chk("stall_last", olast, hl);
                chk("stall_valid", ovalid, 1);
                held = 0;
            end
            oready = cur.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ovalid) begin
                if (oready) begin
                    chk("odata", odata, cur.dout[got]);
                    chk("olast", olast, got == cur.m - 1);
                    got++;
                end else begin
                    held = 1;
                    hd   = odata;
                    hl   = olast;
                end
            end
            @(negedge clk);
            guard++;
        end
        if (got < cur.m) chk("unload_timeout", got, cur.m);
        oready = 1'b0;
        chk("ovalid_drop", ovalid, 0);
    endtask

    task automatic reset_outputs_zero();
        chk("rst_tready", tready, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_olast", olast, 0);
        chk("rst_odata", odata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_err_trunc", err_trunc, 0);
    endtask

    initial begin
        int e0, s0;
        tv = '{default: '0};
        tv[0].n = 4; tv[0].m = 4; tv[0].flen = 4; tv[0].sc = 6;
        tv[0].din[0] = 5; tv[0].din[1] = 3; tv[0].din[2] = 9; tv[0].din[3] = 1;
        tv[0].dout[0] = 1; tv[0].dout[1] = 3; tv[0].dout[2] = 5; tv[0].dout[3] = 9;
        tv[1].n = 1; tv[1].m = 1; tv[1].flen = 1; tv[1].sc = 0;
        tv[1].din[0] = 16'h00AA; tv[1].dout[0] = 16'h00AA;
        tv[2].n = 20; tv[2].m = 16; tv[2].flen = 16; tv[2].err = 1; tv[2].sc = 120;
        for (int k = 0; k < 20; k++) tv[2].din[k] = 16'(20 - k);
        for (int k = 0; k < 16; k++) tv[2].dout[k] = 16'(5 + k);
        tv[3].n = 16; tv[3].m = 16; tv[3].flen = 16; tv[3].sc = 15; tv[3].rnd = 1;
        for (int k = 0; k < 16; k++) begin
            tv[3].din[k]  = 16'(k + 1);
            tv[3].dout[k] = 16'(k + 1);
        end
        tv[4].n = 2; tv[4].m = 2; tv[4].flen = 2; tv[4].sc = 1;
        tv[4].din[0] = 16'h8000; tv[4].din[1] = 16'h0001;
`ifdef SORT_SIGNED_EN
        tv[4].dout[0] = 16'h8000; tv[4].dout[1] = 16'h0001;
`else
        tv[4].dout[0] = 16'h0001; tv[4].dout[1] = 16'h8000;
`endif

        repeat (2) @(negedge clk);
        reset_outputs_zero();
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            cur = tv[v];
            e0 = err_cnt;
            s0 = sort_cnt;
            send_frame();
            if (cur.sc == 0) chk("unload_next_cycle", ovalid, 1);
            recv_frame();
            chk("frame_len", frame_len, cur.flen);
            chk("err_pulses", err_cnt - e0, cur.err);
            chk("sort_cycles", sort_cnt - s0, cur.sc);
        end

        cur = '0;
        cur.n = 16;
        for (int k = 0; k < 16; k++) cur.din[k] = 16'(16 - k);
        send_frame();
        for (int w = 0; w < 20 && !busy; w++) @(negedge clk);
        chk("busy_in_sort", busy, 1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        reset_outputs_zero();
        @(negedge clk);
        reset = 1'b0;

        cur = '0;
        cur.n = 3; cur.m = 3; cur.flen = 3;
        cur.din[0] = 7; cur.din[1] = 2; cur.din[2] = 5;
        cur.dout[0] = 2; cur.dout[1] = 5; cur.dout[2] = 7;
        send_frame();
        recv_frame();
        chk("frame_len_after_reset", frame_len, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/axis_sort_ctrl.md
Name: axis_sort_ctrl

Overview:
Frame-level sequencer for the sort datapath.
- Accepts one AXI-Stream frame on the slave side (tdata/tvalid/tready/tlast) into an internal buffer of 2**ADDRESS words.
- Sorts the buffer in place with a bubble-sort compare/swap engine, one compare per cycle.
- Streams the sorted frame out on the master side (odata/ovalid/oready/olast).
- Sits between the upstream slave_if and the downstream master_if. Processes one frame at a time: load, sort, unload.

Parameters:
- WIDTH, 16, data word width in bits (tdata/odata).
- ADDRESS, 4, buffer address width; buffer depth DEPTH = 2**ADDRESS words.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- tdata  in  WIDTH  slave data
- tvalid  in  1  slave valid
- tlast  in  1  slave last beat of frame
- tready  out  1  slave ready
- odata  out  WIDTH  master data
- ovalid  out  1  master valid
- olast  out  1  master last beat
- oready  in  1  master ready
- busy  out  1  high in SORT or UNLOAD
- frame_len  out  ADDRESS+1  word count of current frame, held until next LOAD
- err_trunc  out  1  one-cycle pulse, frame exceeded DEPTH

Behaviour:
- Reset: state=IDLE, count=0, rd/wr/cmp pointers=0, tready=0, ovalid=0, olast=0, odata=0, busy=0, frame_len=0, err_trunc=0. Buffer contents are not reset.
- Handshake: a transfer occurs on a rising clk edge where valid&&ready. ovalid, once high, stays high and odata/olast stay stable until oready.
- IDLE:
  - Clears count and the trunc flag.
  - Goes to LOAD next cycle; tready=0.
- LOAD:
  - tready=1.
  - Each slave beat with count<DEPTH writes buffer[count] and increments count.
  - Beats with count==DEPTH are accepted and discarded; a sticky trunc flag is set.
  - On a tlast beat:
    - frame_len <= final count, saturating at DEPTH.
    - err_trunc pulses the next cycle if the trunc flag is set or the tlast beat itself was dropped.
    - Goes to SORT if final count>=2; otherwise goes directly to UNLOAD.
- SORT:
  - tready=0, busy=1.
  - Pass loop: i runs from 0 to n-2, one cycle each. If buffer[i] > buffer[i+1] (unsigned), swap them and set the swapped flag.
  - At the end of a pass (i==n-2):
    - If swapped=0, go to UNLOAD.
    - Otherwise clear swapped, set i=0, and start a new pass.
  - Per-pass upper bound shrinks by one after each pass (n-2, n-3, ...). When the bound reaches 0, go to UNLOAD.
  - Worst-case cycles: n*(n-1)/2. Already-sorted input: n-1 cycles.
- UNLOAD:
  - ovalid=1, busy=1, odata=buffer[rd], olast=(rd==frame_len-1).
  - rd increments on each oready handshake.
  - The handshake with olast=1 goes to IDLE. rd is cleared and ovalid drops the following cycle.
  - Stalls on oready=0 indefinitely with outputs stable.
- Output registering: odata/ovalid/olast are driven from registered state/pointer, with no combinational path from oready to ovalid. tready depends only on state.
- Equal values: no swap; sort is stable.
- Reset mid-operation (any state): immediate return to reset values; the partial frame is lost.
- Frame of exactly DEPTH words with tlast on word DEPTH: no err_trunc.

Optional Feature:
- Macro: SORT_SIGNED_EN
- Defined: the comparator treats words as two's-complement signed WIDTH-bit values.
- Undefined: unsigned comparison.
- All other timing is identical in both builds.

Decomposition:
- Package sort_pkg holds:
  - state enum typedef: IDLE, LOAD, SORT, UNLOAD
  - default WIDTH/ADDRESS constants
  - typedef word_t as logic [WIDTH-1:0]
- Sub-module sort_cmp_swap: combinational; inputs a, b; outputs lo, hi, swap.
  - Holds the SORT_SIGNED_EN-dependent compare, so signedness lives in one place.
  - The controller instantiates it once on buffer[i], buffer[i+1].

Test Plan:
- Frame 5,3,9,1 (tlast on 1), oready=1 → output 1,3,5,9; olast on 9; frame_len=4; err_trunc=0.
- Single word 0x00AA with tlast → SORT skipped; UNLOAD next cycle; odata=0x00AA, olast=1.
- 20-word frame, DEPTH=16, values 20 down to 1 → first 16 kept and output as 5..20 ascending; words 4..1 dropped; err_trunc one pulse; frame_len=16.
- Sorted input 1..16 → SORT lasts exactly 15 cycles; output 1..16 unchanged.
- Input 0x8000,0x0001 → output 0x0001,0x8000 without SORT_SIGNED_EN; 0x8000,0x0001 with it.
- Random oready toggling during UNLOAD, plus reset asserted mid-SORT on a second frame → no data change while stalled; after reset, all outputs are at reset values and the next frame sorts correctly.
